// File: rtl/wb_wide_initiator.sv
// Wishbone pipelined initiator: one 64-bit request becomes two 32-bit word accesses
// (low then high) inside a single bus cycle, with a per-word response timeout.
module wb_wide_initiator #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_i,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:3] req_adr_i,
  input  logic [63:0]           req_dat_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [63:0]           rsp_dat_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:2] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LO_STB  = 3'd1;
  localparam logic [2:0] S_LO_WAIT = 3'd2;
  localparam logic [2:0] S_HI_STB  = 3'd3;
  localparam logic [2:0] S_HI_WAIT = 3'd4;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  logic [2:0]            state, state_nxt;
  logic                  we_q;
  logic [ADDR_WIDTH-1:3] adr_q;
  logic [63:0]           wdat_q;
  logic [31:0]           lo_q;
  logic [15:0]           to_cnt, to_cnt_nxt;
  logic                  to_hit;

  logic                  accept, enter_stb, finish, abort, lo_cap, fault;
  logic                  we_l;
  logic [ADDR_WIDTH-1:3] adr_l;
  logic [63:0]           wdat_l;
  logic                  cyc_nxt, stb_nxt, hi_nxt;
  logic [31:0]           dat_nxt;

  always_comb begin
    state_nxt = state;
    enter_stb = '0;
    finish    = '0;
    abort     = '0;
    lo_cap    = '0;
    fault     = wb_err_i | wb_rty_i | to_hit;
    case (state)
      S_IDLE: begin
        if (req_i) begin
          state_nxt = S_LO_STB;
          enter_stb = '1;
        end
      end
      S_LO_STB, S_LO_WAIT: begin
        if (fault) begin
          abort = '1;
        end else if (wb_ack_i) begin
          lo_cap    = '1;
          enter_stb = '1;
          state_nxt = S_HI_STB;
        end else if (state == S_LO_STB && !wb_stall_i) begin
          state_nxt = S_LO_WAIT;
        end
      end
      S_HI_STB, S_HI_WAIT: begin
        if (fault) begin
          abort = '1;
        end else if (wb_ack_i) begin
          finish = '1;
        end else if (state == S_HI_STB && !wb_stall_i) begin
          state_nxt = S_HI_WAIT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort || finish) state_nxt = S_IDLE;
  end

  // Counter restarts at each strobe; to_hit mirrors (to_cnt == TIMEOUT) one register stage early.
  always_comb begin
    if (enter_stb || state_nxt == S_IDLE) to_cnt_nxt = '0;
    else if (to_cnt == '1)                to_cnt_nxt = to_cnt;
    else                                  to_cnt_nxt = to_cnt + 16'd1;
  end

  // Outputs are registered from the next state, so a fresh request uses the live inputs.
  assign accept  = (state == S_IDLE) && req_i;
  assign we_l    = accept ? req_we_i  : we_q;
  assign adr_l   = accept ? req_adr_i : adr_q;
  assign wdat_l  = accept ? req_dat_i : wdat_q;
  assign cyc_nxt = (state_nxt != S_IDLE);
  assign stb_nxt = (state_nxt == S_LO_STB) || (state_nxt == S_HI_STB);
  assign hi_nxt  = (state_nxt == S_HI_STB) || (state_nxt == S_HI_WAIT);
  assign dat_nxt = (cyc_nxt && we_l) ? (hi_nxt ? wdat_l[63:32] : wdat_l[31:0]) : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= S_IDLE;
      we_q      <= '0;
      adr_q     <= '0;
      wdat_q    <= '0;
      lo_q      <= '0;
      to_cnt    <= '0;
      to_hit    <= '0;
      busy_o    <= '0;
      done_o    <= '0;
      err_o     <= '0;
      rsp_dat_o <= '0;
      wb_cyc_o  <= '0;
      wb_stb_o  <= '0;
      wb_we_o   <= '0;
      wb_adr_o  <= '0;
      wb_sel_o  <= '0;
      wb_dat_o  <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
      to_hit <= (to_cnt_nxt == TO_LIMIT);
      if (accept) begin
        we_q   <= req_we_i;
        adr_q  <= req_adr_i;
        wdat_q <= req_dat_i;
      end
      if (lo_cap) lo_q <= wb_dat_i;
      if (finish && !we_q) rsp_dat_o <= {wb_dat_i, lo_q};
      busy_o   <= cyc_nxt;
      done_o   <= finish | abort;
      err_o    <= abort;
      wb_cyc_o <= cyc_nxt;
      wb_stb_o <= stb_nxt;
      wb_we_o  <= cyc_nxt & we_l;
      wb_adr_o <= cyc_nxt ? {adr_l, hi_nxt} : '0;
      wb_sel_o <= cyc_nxt ? 4'hF : 4'h0;
      wb_dat_o <= dat_nxt;
    end
  end

endmodule

// File: tb/tb_wb_wide_initiator.sv
// Self-checking bench for wb_wide_initiator: configurable 32-bit responder plus a
// word-level reference memory and latency model.
module tb_wb_wide_initiator;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [7:3]  req_adr_i = '0;
  logic [63:0] req_dat_i = '0;
  logic        busy_o, done_o, err_o;
  logic [63:0] rsp_dat_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:2]  wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;

  wb_wide_initiator #(.ADDR_WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_i(req_i), .req_we_i(req_we_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rsp_dat_o(rsp_dat_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i)
  );

  always #5 clk = ~clk;

  // ---------------- responder ----------------
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int unsigned stall_n = 0, ack_dly = 0, bad_word = 0, silent_word = 0;
  bit          bad_rty = 1'b0, bad_ack_too = 1'b0;
  int unsigned age, pend;
  logic        rsp_stall, accept_s, fire, is_bad, is_silent;
  logic        ld_en = 1'b0;
  logic [5:0]  ld_idx = '0;
  logic [31:0] ld_val = '0;

  always_comb begin
    rsp_stall  = wb_stb_o && (age < stall_n);
    accept_s   = wb_stb_o && !rsp_stall;
    is_bad     = (bad_word == 1 && !wb_adr_o[2]) || (bad_word == 2 && wb_adr_o[2]);
    is_silent  = (silent_word == 1 && !wb_adr_o[2]) || (silent_word == 2 && wb_adr_o[2]);
    fire       = wb_cyc_o && !is_silent && ((accept_s && ack_dly == 0) || pend == 1);
    wb_stall_i = rsp_stall;
    wb_ack_i   = fire && (!is_bad || bad_ack_too);
    wb_err_i   = fire && is_bad && !bad_rty;
    wb_rty_i   = fire && is_bad && bad_rty;
    wb_dat_i   = mem[wb_adr_o];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age  <= 0;
      pend <= 0;
    end else begin
      if (wb_stb_o && rsp_stall) age <= age + 1;
      else                       age <= 0;
      if (accept_s && ack_dly != 0) pend <= ack_dly;
      else if (pend != 0)           pend <= pend - 1;
    end
  end

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (wb_ack_i && !wb_err_i && !wb_rty_i && wb_we_o) mem[wb_adr_o] <= wb_dat_o;
  end

  // ---------------- bus protocol monitor ----------------
  int unsigned stab_viol = 0, rd_dat_viol = 0, sel_viol = 0;
  logic        prev_stb = 1'b0, prev_prog = 1'b0, prev_we = 1'b0;
  logic [7:2]  prev_adr = '0;
  logic [31:0] prev_dat = '0;
  logic [7:2]  adr_log [$];

  always @(negedge clk) begin
    if (wb_stb_o && prev_stb && !prev_prog &&
        (wb_adr_o != prev_adr || wb_we_o != prev_we || wb_dat_o != prev_dat))
      stab_viol <= stab_viol + 1;
    if (wb_stb_o && !wb_we_o && wb_dat_o != '0) rd_dat_viol <= rd_dat_viol + 1;
    if (wb_sel_o != (wb_cyc_o ? 4'hF : 4'h0)) sel_viol <= sel_viol + 1;
    if (wb_cyc_o && (wb_ack_i || wb_err_i || wb_rty_i)) adr_log.push_back(wb_adr_o);
    prev_stb  <= wb_stb_o;
    prev_prog <= wb_ack_i || wb_err_i || wb_rty_i || !wb_stall_i;
    prev_we   <= wb_we_o;
    prev_adr  <= wb_adr_o;
    prev_dat  <= wb_dat_o;
  end

  // ---------------- checking ----------------
  int unsigned vectors = 0, miscompares = 0;
  logic [63:0] exp_rsp = '0;
  bit          rsp_known = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int unsigned idx, input logic [31:0] v);
    ld_idx = 6'(idx);
    ld_val = v;
    ld_en  = 1'b1;
    ref_mem[idx] = v;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic cfg(input int unsigned s, input int unsigned dl, input int unsigned bw,
                     input bit rty, input bit both, input int unsigned sw);
    stall_n = s; ack_dly = dl; bad_word = bw; bad_rty = rty; bad_ack_too = both;
    silent_word = sw;
  endtask

  // One 64-bit request; expected latency: each word lasts stall+1+ack_delay cycles,
  // a timed-out word aborts TIMEOUT+1 cycles after its strobe starts.
  task automatic run_txn(input string tag, input bit we, input logic [4:0] a,
                         input logic [63:0] d, input int unsigned s, input int unsigned dl,
                         input int unsigned bw, input bit rty, input bit both,
                         input int unsigned sw);
    int unsigned lat, gap, wl, exp_lat;
    bit exp_err;
    @(negedge clk);
    cfg(s, dl, bw, rty, both, sw);
    req_we_i = we; req_adr_i = a; req_dat_i = d; req_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    lat = 1; gap = 0;
    while (!done_o && lat < 100) begin
      if (!wb_cyc_o) gap++;
      @(negedge clk);
      lat++;
    end
    wl = s + 1 + dl;
    if (sw != 0)      begin exp_lat = (sw - 1) * wl + TIMEOUT + 2; exp_err = 1'b1; end
    else if (bw != 0) begin exp_lat = 1 + bw * wl;                 exp_err = 1'b1; end
    else              begin exp_lat = 1 + 2 * wl;                  exp_err = 1'b0; end
    check({tag, " done"}, 64'(done_o), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " err"}, 64'(err_o), 64'(exp_err));
    check({tag, " cyc gap"}, 64'(gap), 64'd0);
    if (!exp_err && !we) begin
      exp_rsp   = {ref_mem[{a, 1'b1}], ref_mem[{a, 1'b0}]};
      rsp_known = 1'b1;
    end
    if (!exp_err && we) rsp_known = 1'b0;
    if (rsp_known) check({tag, " rsp"}, rsp_dat_o, exp_rsp);
    if (we && bw != 1 && sw != 1) ref_mem[{a, 1'b0}] = d[31:0];
    if (we && bw == 0 && sw == 0) ref_mem[{a, 1'b1}] = d[63:32];
    @(negedge clk);
    check({tag, " idle after"}, 64'({done_o, wb_cyc_o, wb_stb_o, busy_o}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, k, bad_cnt;
    bit          r_we, r_rty;
    logic [4:0]  r_a;
    logic [63:0] r_d;
    int unsigned r_s, r_dl, r_bw, r_sw, r_sel;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ctl", 64'({busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
    check("reset bus", 64'({wb_sel_o, wb_adr_o, wb_dat_o}), 64'd0);
    check("reset rsp", rsp_dat_o, 64'd0);
    for (int unsigned i = 0; i < 64; i++) preload(i, $urandom);
    preload(4, 32'h11223344);
    preload(5, 32'hAABBCCDD);
    @(negedge clk);
    rst_n = 1'b1;

    // zero-wait read
    adr_log.delete();
    run_txn("rd0", 1'b0, 5'd2, '0, 0, 0, 0, 1'b0, 1'b0, 0);
    check("rd0 value", rsp_dat_o, 64'hAABBCCDD11223344);
    check("rd0 nwords", 64'(adr_log.size()), 64'd2);
    check("rd0 adr lo", 64'(adr_log[0]), 64'h4);
    check("rd0 adr hi", 64'(adr_log[1]), 64'h5);

    // write with 3 stall cycles per word
    run_txn("wr_stall", 1'b1, 5'd3, 64'h0123456789ABCDEF, 3, 0, 0, 1'b0, 1'b0, 0);
    check("wr_stall mem lo", 64'(mem[6]), 64'h89ABCDEF);
    check("wr_stall mem hi", 64'(mem[7]), 64'h01234567);

    // error on the high word keeps the previous read data
    run_txn("rd1", 1'b0, 5'd7, '0, 0, 1, 0, 1'b0, 1'b0, 0);
    run_txn("err_hi", 1'b0, 5'd8, '0, 0, 0, 2, 1'b0, 1'b0, 0);

    // timeout on a silent responder, then a normal read
    run_txn("to_lo", 1'b0, 5'd9, '0, 0, 0, 0, 1'b0, 1'b0, 1);
    run_txn("after_to", 1'b0, 5'd10, '0, 0, 0, 0, 1'b0, 1'b0, 0);
    run_txn("to_hi", 1'b1, 5'd11, 64'hDEADBEEF_CAFEF00D, 1, 0, 0, 1'b0, 1'b0, 2);

    // err and ack together, retry treated as error
    run_txn("err_ack", 1'b0, 5'd12, '0, 0, 0, 1, 1'b0, 1'b1, 0);
    run_txn("rty_lo", 1'b1, 5'd13, 64'h1111_2222_3333_4444, 0, 1, 1, 1'b1, 1'b0, 0);
    run_txn("rty_hi", 1'b0, 5'd14, '0, 1, 0, 2, 1'b1, 1'b0, 0);

    // back-to-back with req_i held high
    run_txn("pre_b2b", 1'b0, 5'd1, '0, 0, 0, 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    cfg(0, 0, 0, 1'b0, 1'b0, 0);
    req_we_i = 1'b0; req_adr_i = 5'd9; req_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_adr_i = 5'd12;
    n = 1;
    while (!done_o && n < 50) begin @(negedge clk); n++; end
    check("b2b1 done", 64'(done_o), 64'd1);
    check("b2b1 latency", 64'(n), 64'd3);
    check("b2b1 rsp", rsp_dat_o, {ref_mem[19], ref_mem[18]});
    check("b2b1 busy in done", 64'(busy_o), 64'd0);
    @(negedge clk);
    req_i = 1'b0;
    check("b2b2 started", 64'({busy_o, wb_stb_o, wb_adr_o}), {56'd0, 1'b1, 1'b1, 6'd24});
    n = 1;
    while (!done_o && n < 50) begin @(negedge clk); n++; end
    check("b2b2 latency", 64'(n), 64'd3);
    check("b2b2 err", 64'(err_o), 64'd0);
    check("b2b2 rsp", rsp_dat_o, {ref_mem[25], ref_mem[24]});
    exp_rsp = {ref_mem[25], ref_mem[24]};
    rsp_known = 1'b1;
    @(negedge clk);
    check("b2b no third", 64'({wb_cyc_o, busy_o}), 64'd0);

    // randomized transfers
    for (int unsigned i = 0; i < 24; i++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_a   = 5'($urandom_range(0, 31));
      r_d   = {$urandom, $urandom};
      r_s   = $urandom_range(0, 2);
      r_dl  = $urandom_range(0, 3 - r_s);
      r_sel = $urandom_range(0, 7);
      r_bw  = 0; r_sw = 0; r_rty = 1'b0;
      if (r_sel == 0) begin
        r_bw  = $urandom_range(1, 2);
        r_rty = 1'($urandom_range(0, 1));
      end else if (r_sel == 1) begin
        r_sw  = $urandom_range(1, 2);
      end
      run_txn($sformatf("rnd%0d", i), r_we, r_a, r_d, r_s, r_dl, r_bw, r_rty, 1'b0, r_sw);
    end

    // asynchronous reset while waiting on the high word
    @(negedge clk);
    cfg(0, 3, 0, 1'b0, 1'b0, 0);
    req_we_i = 1'b0; req_adr_i = 5'd20; req_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    k = 0;
    while (!(wb_cyc_o && !wb_stb_o && wb_adr_o[2]) && k < 20) begin @(negedge clk); k++; end
    check("hi_wait reached", 64'({wb_cyc_o, wb_stb_o, wb_adr_o[2]}), 64'b101);
    #2 rst_n = 1'b0;
    #1 check("async reset", 64'({wb_cyc_o, wb_stb_o, busy_o, done_o}), 64'd0);
    bad_cnt = 0;
    repeat (2) begin @(negedge clk); if (done_o || wb_cyc_o) bad_cnt++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done_o || wb_cyc_o) bad_cnt++; end
    check("no done after reset", 64'(bad_cnt), 64'd0);
    check("rsp cleared", rsp_dat_o, 64'd0);
    exp_rsp = '0;
    rsp_known = 1'b1;
    run_txn("post_rst", 1'b0, 5'd20, '0, 1, 1, 0, 1'b0, 1'b0, 0);

    // bus protocol and final memory image
    check("stb stability", 64'(stab_viol), 64'd0);
    check("read dat_o zero", 64'(rd_dat_viol), 64'd0);
    check("sel", 64'(sel_viol), 64'd0);
    bad_cnt = 0;
    for (int unsigned i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad_cnt++;
    check("memory image", 64'(bad_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
